// File: rtl/cordic_q15_to_fp32_pkg.sv
// Shared constants for the Q1.15 -> IEEE-754 single converter: FP32 field layout
// and FSM state encodings.
package cordic_q15_to_fp32_pkg;

    localparam int FP32_BIAS   = 127;
    localparam int FP32_EXP_W  = 8;
    localparam int FP32_FRAC_W = 23;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NORM = 2'd1;
    localparam logic [1:0] ST_PACK = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    function automatic logic [31:0] fp32_pack(
        input logic                   sign,
        input logic [FP32_EXP_W-1:0]  exp_f,
        input logic [FP32_FRAC_W-1:0] frac_f
    );
        return {sign, exp_f, frac_f};
    endfunction

endpackage

// File: rtl/cordic_q15_to_fp32_if.sv
// Bus between cordic_top-side producer, the converter and its downstream consumer.
// Handshake: a pair is taken on a rising edge with valid_in && ready_in; a result
// leaves on a rising edge with valid_out && out_ready, and valid_out plus the result
// words stay unchanged until that edge.
interface cordic_q15_to_fp32_if #(
    parameter int IN_W = 16
);
    logic                   valid_in;
    logic                   ready_in;
    logic signed [IN_W-1:0] sin_q15;
    logic signed [IN_W-1:0] cos_q15;
    logic [2:0]             flip_in;
    logic [31:0]            sin_fp32;
    logic [31:0]            cos_fp32;
    logic [2:0]             flip_out;
    logic                   valid_out;
    logic                   out_ready;
    logic                   overrun;
    logic [1:0]             state_dbg;

    modport slave (
        input  valid_in, sin_q15, cos_q15, flip_in, out_ready,
        output ready_in, sin_fp32, cos_fp32, flip_out, valid_out, overrun, state_dbg
    );

    modport master (
        output valid_in, sin_q15, cos_q15, flip_in, out_ready,
        input  ready_in, sin_fp32, cos_fp32, flip_out, valid_out, overrun, state_dbg
    );
endinterface

// File: rtl/cordic_fp32_norm.sv
// Iterative left-normaliser: shifts a loaded magnitude until its MSB is set (or it is
// zero), counting the shifts taken.
module cordic_fp32_norm #(
    parameter int IN_W = 16,
    parameter int S_W  = $clog2(IN_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [IN_W-1:0] load_mag,
    input  logic            shift_en,
    output logic [IN_W-1:0] mag,
    output logic [S_W-1:0]  s,
    output logic            done
);

    assign done = (mag == '0) || mag[IN_W-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag <= '0;
            s   <= '0;
        end else if (load) begin
            mag <= load_mag;
            s   <= '0;
        end else if (shift_en && !done) begin
            mag <= {mag[IN_W-2:0], 1'b0};
            s   <= s + 1'b1;
        end
    end

endmodule

// File: rtl/cordic_q15_to_fp32.sv
// Converts a captured Q1.15 sin/cos pair to two FP32 words through one shared
// normaliser (sin, then cos), passing the flip code through.
module cordic_q15_to_fp32
    import cordic_q15_to_fp32_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 15
) (
    input logic                  clk,
    input logic                  rst,
    cordic_q15_to_fp32_if.slave  bus
);

    localparam int S_W     = $clog2(IN_W);
    localparam int EXP_OFF = FP32_BIAS + (IN_W - 1 - FRAC_W);
    localparam int PAD_W   = FP32_FRAC_W - (IN_W - 1);

    logic [1:0]      state;
    logic            sel;
    logic            sin_sign;
    logic [IN_W-1:0] cos_hold;
    logic [31:0]     sin_word;
    logic [31:0]     cos_word;
    logic [2:0]      flip_q;
    logic            overrun_q;

    logic            load;
    logic            shift_en;
    logic [IN_W-1:0] load_mag;
    logic [IN_W-1:0] mag;
    logic [S_W-1:0]  s;
    logic            done;

    logic                   cur_sign;
    logic [FP32_EXP_W-1:0]  exp_w;
    logic [FP32_FRAC_W-1:0] frac_w;
    logic [31:0]            pack_word;

    // Two's-complement negate; the most negative code maps to 100..0 unsigned.
    function automatic logic [IN_W-1:0] mag_of(input logic [IN_W-1:0] v);
        return v[IN_W-1] ? -v : v;
    endfunction

    cordic_fp32_norm #(.IN_W(IN_W), .S_W(S_W)) u_norm (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_mag (load_mag),
        .shift_en (shift_en),
        .mag      (mag),
        .s        (s),
        .done     (done)
    );

    assign cur_sign  = sel ? cos_hold[IN_W-1] : sin_sign;
    assign exp_w     = FP32_EXP_W'(EXP_OFF) - FP32_EXP_W'(s);
    assign frac_w    = {mag[IN_W-2:0], {PAD_W{1'b0}}};
    assign pack_word = (mag == '0) ? FP32_ZERO : fp32_pack(cur_sign, exp_w, frac_w);

    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        load_mag = (state == ST_PACK) ? mag_of(cos_hold) : mag_of(bus.sin_q15);
        case (state)
            ST_IDLE: load     = bus.valid_in;
            ST_NORM: shift_en = !done;
            ST_PACK: load     = !sel;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            sel       <= 1'b0;
            sin_sign  <= 1'b0;
            cos_hold  <= '0;
            sin_word  <= '0;
            cos_word  <= '0;
            flip_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.valid_in && (state != ST_IDLE))
                overrun_q <= 1'b1;
            case (state)
                ST_IDLE: if (bus.valid_in) begin
                    sin_sign <= bus.sin_q15[IN_W-1];
                    cos_hold <= bus.cos_q15;
                    flip_q   <= bus.flip_in;
                    sel      <= 1'b0;
                    state    <= ST_NORM;
                end
                ST_NORM: if (done) state <= ST_PACK;
                ST_PACK: if (!sel) begin
                    sin_word <= pack_word;
                    sel      <= 1'b1;
                    state    <= ST_NORM;
                end else begin
                    cos_word <= pack_word;
                    state    <= ST_OUT;
                end
                ST_OUT: if (bus.out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_in  = (state == ST_IDLE);
    assign bus.valid_out = (state == ST_OUT);
    assign bus.sin_fp32  = sin_word;
    assign bus.cos_fp32  = cos_word;
    assign bus.flip_out  = flip_q;
    assign bus.overrun   = overrun_q;
    assign bus.state_dbg = state;

endmodule
